// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides.
// Results carry zero and parity flags; a counter tracks completed output handshakes.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [2:0] OP_BUF  = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [2:0]       s1_op_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_result_reg;
    logic             s2_zero_reg;
    logic             s2_parity_reg;
    logic [CNT_W-1:0] count_reg;

    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] result_next;
    logic             zero_next;
    logic             parity_next;
    logic [CNT_W-1:0] count_next;

    // A stage may move when it is empty or its downstream is moving this cycle.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic a_bit;
            logic b_bit;
            logic f_bit;

            assign a_bit = s1_a_reg[gi];
            assign b_bit = s1_b_reg[gi];

            always_comb begin
                f_bit = a_bit;
                unique case (s1_op_reg)
                    OP_BUF:  f_bit = a_bit;
                    OP_NOT:  f_bit = ~a_bit;
                    OP_AND:  f_bit = a_bit & b_bit;
                    OP_OR:   f_bit = a_bit | b_bit;
                    OP_XOR:  f_bit = a_bit ^ b_bit;
                    OP_NAND: f_bit = ~(a_bit & b_bit);
                    OP_NOR:  f_bit = ~(a_bit | b_bit);
                    OP_XNOR: f_bit = ~(a_bit ^ b_bit);
                    default: f_bit = a_bit;
                endcase
            end

            assign result_next[gi] = f_bit;
        end
    endgenerate

    assign zero_next   = (result_next == '0);
    assign parity_next = ^result_next;
    assign count_next  = (s2_valid_reg && out_ready) ? count_reg + CNT_W'(1) : count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            // Data holds when no new operand arrives; only valid drops.
            if (in_valid) begin
                s1_a_reg  <= in_a;
                s1_b_reg  <= in_b;
                s1_op_reg <= in_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_zero_reg   <= 1'b0;
            s2_parity_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_result_reg <= result_next;
                s2_zero_reg   <= zero_next;
                s2_parity_reg <= parity_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_result = s2_result_reg;
    assign out_zero   = s2_zero_reg;
    assign out_parity = s2_parity_reg;
    assign txn_count  = count_reg;

endmodule
